mem_access: RTL and testbench

Memory-access pipeline stage of the toy CPU, between the EX/MEM pipeline register and the MEM/WB register. It passes ALU results straight through. It runs loads and stores as a request/acknowledge transaction on the data-memory bus, stalling the pipeline until the transaction completes. It handles byte and halfword lane selection, load sign or zero extension, store byte enables, misalignment and bus timeout.

---
 rtl/mem_access_if.sv | 32 +++
 rtl/mem_access.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Pipeline-side and data-memory-side signals of the memory-access stage.
// The stage itself uses the slave modport; its environment uses master.
interface mem_access_if;
  logic [4:0]  ex_regDest;
  logic [31:0] ex_value;
  logic [3:0]  ex_memOp;
  logic [31:0] ex_storeData;
  logic [4:0]  mem_regDest;
  logic [31:0] mem_value;
  logic        mem_stall;
  logic        mem_misaligned;
  logic        mem_busErr;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport slave (
    input  ex_regDest, ex_value, ex_memOp, ex_storeData, dmem_rdata, dmem_ack,
    output mem_regDest, mem_value, mem_stall, mem_misaligned, mem_busErr,
           dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );

  modport master (
    output ex_regDest, ex_value, ex_memOp, ex_storeData, dmem_rdata, dmem_ack,
    input  mem_regDest, mem_value, mem_stall, mem_misaligned, mem_busErr,
           dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: ALU pass-through, load/store bus transactions
// with lane selection, load extension, misalignment detection and ack timeout.
module mem_access #(
  parameter int ACK_TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  mem_access_if.slave bus
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam bit TO_EN = (ACK_TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_result;
  logic          r_err;
  logic          r_req;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;

  logic          w_is_load;
  logic          w_is_store;
  logic [1:0]    w_size;
  logic          w_misaligned;
  logic          w_issue;
  logic          w_timeout;

  function automatic logic [31:0] f_load_ext(input logic [3:0] op,
                                             input logic [1:0] lane,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*lane +: 8];
    h = rdata[16*lane[1] +: 16];
    case (op)
      OP_LB:   f_load_ext = {{24{b[7]}}, b};
      OP_LBU:  f_load_ext = {24'd0, b};
      OP_LH:   f_load_ext = {{16{h[15]}}, h};
      OP_LHU:  f_load_ext = {16'd0, h};
      OP_LW:   f_load_ext = rdata;
      default: f_load_ext = 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] f_store_be(input logic [1:0] size,
                                            input logic [1:0] lane);
    case (size)
      2'd0:    f_store_be = 4'b0001 << lane;
      2'd1:    f_store_be = lane[1] ? 4'b1100 : 4'b0011;
      default: f_store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_store_wdata(input logic [1:0] size,
                                                input logic [31:0] data);
    case (size)
      2'd0:    f_store_wdata = {4{data[7:0]}};
      2'd1:    f_store_wdata = {2{data[15:0]}};
      default: f_store_wdata = data;
    endcase
  endfunction

  // Operation decode: class, access size and alignment.
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_size     = 2'd2;
    case (bus.ex_memOp)
      OP_LB, OP_LBU:   begin w_is_load = 1'b1;  w_size = 2'd0; end
      OP_LH, OP_LHU:   begin w_is_load = 1'b1;  w_size = 2'd1; end
      OP_LW:           begin w_is_load = 1'b1;  w_size = 2'd2; end
      OP_SB:           begin w_is_store = 1'b1; w_size = 2'd0; end
      OP_SH:           begin w_is_store = 1'b1; w_size = 2'd1; end
      OP_SW:           begin w_is_store = 1'b1; w_size = 2'd2; end
      default:         begin w_is_load = 1'b0;  w_is_store = 1'b0; end
    endcase
    if (w_size == 2'd1) begin
      w_misaligned = bus.ex_value[0];
    end else if (w_size == 2'd2) begin
      w_misaligned = (bus.ex_value[1:0] != 2'b00);
    end else begin
      w_misaligned = 1'b0;
    end
    w_issue   = (w_is_load || w_is_store) && !w_misaligned;
    w_timeout = TO_EN && (r_cnt == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_next = BUSY;
        end else begin
          w_next = IDLE;
        end
      end
      BUSY: begin
        if (bus.dmem_ack || w_timeout) begin
          w_next = DONE;
        end else begin
          w_next = BUSY;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pipeline-facing outputs; IDLE is a zero-latency pass-through.
  always_comb begin
    bus.mem_regDest    = 5'd0;
    bus.mem_value      = 32'd0;
    bus.mem_stall      = 1'b0;
    bus.mem_misaligned = 1'b0;
    bus.mem_busErr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          bus.mem_stall = 1'b1;
        end else if (w_misaligned && (w_is_load || w_is_store)) begin
          bus.mem_misaligned = 1'b1;
        end else begin
          bus.mem_regDest = bus.ex_regDest;
          bus.mem_value   = bus.ex_value;
        end
      end
      BUSY: bus.mem_stall = 1'b1;
      DONE: begin
        bus.mem_busErr = r_err;
        if (w_is_load && !r_err) begin
          bus.mem_regDest = bus.ex_regDest;
          bus.mem_value   = r_result;
        end else begin
          bus.mem_regDest = 5'd0;
        end
      end
      default: bus.mem_stall = 1'b0;
    endcase
  end

  // Bus registers, timeout counter, captured load data and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_result <= 32'd0;
      r_err    <= 1'b0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_req   <= 1'b1;
            r_we    <= w_is_store;
            r_addr  <= {bus.ex_value[31:2], 2'b00};
            r_be    <= f_store_be(w_size, bus.ex_value[1:0]);
            r_wdata <= f_store_wdata(w_size, bus.ex_storeData);
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end
        end
        BUSY: begin
          if (bus.dmem_ack) begin
            r_result <= f_load_ext(bus.ex_memOp, bus.ex_value[1:0], bus.dmem_rdata);
            r_req    <= 1'b0;
            r_we     <= 1'b0;
          end else if (w_timeout) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_err <= r_err;
      endcase
    end
  end

  assign bus.dmem_req   = r_req;
  assign bus.dmem_we    = r_we;
  assign bus.dmem_addr  = r_addr;
  assign bus.dmem_be    = r_be;
  assign bus.dmem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// operations compared against a byte-arithmetic reference model.
module tb_mem_access;

  localparam int TMO = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_access_if bus ();

  mem_access #(.ACK_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations recorded by run_op for the calling test to judge.
  logic [4:0]  o_idle_rd;
  logic [31:0] o_idle_val;
  logic        o_idle_stall, o_idle_mis, o_idle_req;
  int          o_stall, o_req;
  logic        o_stable, o_hung;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        o_we;
  logic [4:0]  o_done_rd;
  logic [31:0] o_done_val;
  logic        o_done_err, o_done_req, o_next_req;

  function automatic int nbytes(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2 || op == 4'd6) return 1;
    if (op == 4'd3 || op == 4'd4 || op == 4'd7) return 2;
    return 4;
  endfunction

  function automatic bit is_mem(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic bit is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic bit is_misaligned(input logic [3:0] op, input logic [31:0] addr);
    return is_mem(op) && ((addr % nbytes(op)) != 0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int n;
    logic [31:0] v, mask;
    n = nbytes(op);
    v = rdata >> (8 * (addr % 4));
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if ((op == 4'd1 || op == 4'd3) && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] addr);
    int b;
    b = ((1 << nbytes(op)) - 1) << (addr % 4);
    return b[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] data);
    if (nbytes(op) == 1) return {24'd0, data[7:0]} * 32'h01010101;
    if (nbytes(op) == 2) return {16'd0, data[15:0]} * 32'h00010001;
    return data;
  endfunction

  // Drives one operation from IDLE and follows the stall until the stage is back in IDLE.
  task automatic run_op(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] data, input int ackn, input logic [31:0] rdata);
    bus.ex_memOp     = op;
    bus.ex_regDest   = rd;
    bus.ex_value     = addr;
    bus.ex_storeData = data;
    bus.dmem_ack     = 1'b0;
    @(negedge clk);
    o_idle_rd = bus.mem_regDest;  o_idle_val = bus.mem_value;
    o_idle_stall = bus.mem_stall; o_idle_mis = bus.mem_misaligned;
    o_idle_req = bus.dmem_req;
    o_stall = o_idle_stall ? 1 : 0;
    o_req = 0; o_stable = 1'b1; o_hung = 1'b0;
    o_done_rd = 5'd0; o_done_val = 32'd0; o_done_err = 1'b0; o_done_req = 1'b0;
    if (o_idle_stall) begin
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        bus.dmem_ack   = (k == ackn);
        bus.dmem_rdata = (k == ackn) ? rdata : $urandom;
        @(negedge clk);
        if (!bus.mem_stall) begin
          o_done_rd = bus.mem_regDest; o_done_val = bus.mem_value;
          o_done_err = bus.mem_busErr; o_done_req = bus.dmem_req;
          break;
        end
        o_stall++;
        if (bus.dmem_req) o_req++;
        if (k == 1) begin
          o_addr = bus.dmem_addr; o_be = bus.dmem_be; o_we = bus.dmem_we; o_wdata = bus.dmem_wdata;
        end else if (o_addr !== bus.dmem_addr || o_be !== bus.dmem_be ||
                     (bus.dmem_req && (o_we !== bus.dmem_we || o_wdata !== bus.dmem_wdata))) begin
          o_stable = 1'b0;
        end
        if (k == 20) o_hung = 1'b1;
      end
    end
    @(posedge clk); #1;
    bus.dmem_ack = 1'b0;
    o_next_req = bus.dmem_req;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.ex_memOp = 4'd0; bus.ex_regDest = 5'd7; bus.ex_value = 32'hCAFE0001;
    bus.ex_storeData = 32'd0; bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
    #12;
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.dmem_req); end
    checks++; if (bus.dmem_addr !== 32'd0 || bus.dmem_be !== 4'd0 || bus.dmem_wdata !== 32'd0 || bus.dmem_we !== 1'b0) begin
      errors++; $display("FAIL reset_bus got addr=%h be=%b wdata=%h we=%b exp=0", bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, bus.dmem_we); end
    checks++; if (bus.mem_regDest !== 5'd7 || bus.mem_value !== 32'hCAFE0001 || bus.mem_stall !== 1'b0) begin
      errors++; $display("FAIL reset_passthru got rd=%0d val=%h stall=%b exp rd=7 val=cafe0001 stall=0", bus.mem_regDest, bus.mem_value, bus.mem_stall); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough;
    run_op(4'd0, 5'd5, 32'h1234, 32'd0, 0, 32'd0);
    checks++; if (o_idle_rd !== 5'd5 || o_idle_val !== 32'h1234) begin
      errors++; $display("FAIL passthru got rd=%0d val=%h exp rd=5 val=1234", o_idle_rd, o_idle_val); end
    checks++; if (o_idle_stall !== 1'b0 || o_idle_req !== 1'b0 || o_next_req !== 1'b0) begin
      errors++; $display("FAIL passthru_nostall got stall=%b req=%b/%b exp 0", o_idle_stall, o_idle_req, o_next_req); end
    run_op(4'd12, 5'd3, 32'h0000_0203, 32'd0, 1, 32'd0);
    checks++; if (o_idle_rd !== 5'd3 || o_idle_stall !== 1'b0 || o_next_req !== 1'b0) begin
      errors++; $display("FAIL op12_as_none got rd=%0d stall=%b req=%b exp rd=3 stall=0 req=0", o_idle_rd, o_idle_stall, o_next_req); end
  endtask

  task automatic test_load_ext;
    run_op(4'd1, 5'd4, 32'h103, 32'd0, 2, 32'h80FF1234);
    checks++; if (o_stall != 3) begin errors++; $display("FAIL lb_stall got=%0d exp=3", o_stall); end
    checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL lb_addr got=%h exp=00000100", o_addr); end
    checks++; if (o_done_val !== 32'hFFFFFF80 || o_done_rd !== 5'd4) begin
      errors++; $display("FAIL lb_value got val=%h rd=%0d exp val=ffffff80 rd=4", o_done_val, o_done_rd); end
    run_op(4'd2, 5'd4, 32'h103, 32'd0, 2, 32'h80FF1234);
    checks++; if (o_done_val !== 32'h00000080) begin errors++; $display("FAIL lbu_value got=%h exp=00000080", o_done_val); end
  endtask

  task automatic test_store_half;
    run_op(4'd7, 5'd6, 32'h202, 32'h0000ABCD, 1, 32'd0);
    checks++; if (o_we !== 1'b1 || o_be !== 4'b1100) begin errors++; $display("FAIL sh_we_be got we=%b be=%b exp we=1 be=1100", o_we, o_be); end
    checks++; if (o_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got=%h exp=abcdabcd", o_wdata); end
    checks++; if (o_done_rd !== 5'd0 || o_stall != 2) begin errors++; $display("FAIL sh_done got rd=%0d stall=%0d exp rd=0 stall=2", o_done_rd, o_stall); end
  endtask

  task automatic test_misaligned;
    run_op(4'd5, 5'd9, 32'h101, 32'd0, 1, 32'd0);
    checks++; if (o_idle_mis !== 1'b1 || o_idle_stall !== 1'b0) begin
      errors++; $display("FAIL mis_flag got mis=%b stall=%b exp mis=1 stall=0", o_idle_mis, o_idle_stall); end
    checks++; if (o_idle_rd !== 5'd0 || o_idle_val !== 32'd0 || o_next_req !== 1'b0) begin
      errors++; $display("FAIL mis_noreq got rd=%0d val=%h req=%b exp 0", o_idle_rd, o_idle_val, o_next_req); end
    run_op(4'd0, 5'd1, 32'h0, 32'd0, 0, 32'd0);
    checks++; if (o_idle_mis !== 1'b0) begin errors++; $display("FAIL mis_pulse got=%b exp=0", o_idle_mis); end
  endtask

  task automatic test_timeout;
    run_op(4'd5, 5'd11, 32'h40, 32'd0, 0, 32'd0);
    checks++; if (o_req != TMO) begin errors++; $display("FAIL tmo_req_cycles got=%0d exp=%0d", o_req, TMO); end
    checks++; if (o_done_err !== 1'b1 || o_done_rd !== 5'd0 || o_done_req !== 1'b0) begin
      errors++; $display("FAIL tmo_done got err=%b rd=%0d req=%b exp err=1 rd=0 req=0", o_done_err, o_done_rd, o_done_req); end
    run_op(4'd5, 5'd11, 32'h40, 32'd0, TMO, 32'h13579BDF);
    checks++; if (o_done_err !== 1'b0 || o_done_rd !== 5'd11 || o_done_val !== 32'h13579BDF) begin
      errors++; $display("FAIL tmo_lastack got err=%b rd=%0d val=%h exp err=0 rd=11 val=13579bdf", o_done_err, o_done_rd, o_done_val); end
  endtask

  task automatic test_reset_mid;
    bus.ex_memOp = 4'd5; bus.ex_regDest = 5'd2; bus.ex_value = 32'h80; bus.dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy_req got=%b exp=1", bus.dmem_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || bus.dmem_addr !== 32'd0) begin
      errors++; $display("FAIL rstmid_req got req=%b addr=%h exp req=0 addr=0", bus.dmem_req, bus.dmem_addr); end
    bus.ex_memOp = 4'd0;
    #1;
    checks++; if (bus.mem_stall !== 1'b0 || bus.mem_regDest !== 5'd2) begin
      errors++; $display("FAIL rstmid_idle got stall=%b rd=%0d exp stall=0 rd=2", bus.mem_stall, bus.mem_regDest); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_op(4'd5, 5'd9, 32'h10, 32'd0, 1, 32'hDEADBEEF);
    checks++; if (o_done_val !== 32'hDEADBEEF || o_done_rd !== 5'd9) begin
      errors++; $display("FAIL rstmid_after got val=%h rd=%0d exp val=deadbeef rd=9", o_done_val, o_done_rd); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] addr, data, rdata;
    int          ackn, e_stall;
    bit          ok;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15)); rd = 5'($urandom); addr = $urandom;
      data = $urandom; rdata = $urandom; ackn = $urandom_range(0, 6);
      run_op(op, rd, addr, data, ackn, rdata);
      if (!is_mem(op)) begin
        checks++; if (o_idle_rd !== rd || o_idle_val !== addr || o_idle_stall !== 1'b0) begin
          errors++; $display("FAIL rnd_none[%0d] got rd=%0d val=%h stall=%b exp rd=%0d val=%h stall=0", i, o_idle_rd, o_idle_val, o_idle_stall, rd, addr); end
      end else if (is_misaligned(op, addr)) begin
        checks++; if (o_idle_mis !== 1'b1 || o_idle_rd !== 5'd0 || o_idle_stall !== 1'b0 || o_next_req !== 1'b0) begin
          errors++; $display("FAIL rnd_mis[%0d] got mis=%b rd=%0d stall=%b req=%b exp 1/0/0/0", i, o_idle_mis, o_idle_rd, o_idle_stall, o_next_req); end
      end else begin
        ok = (ackn >= 1) && (ackn <= TMO);
        e_stall = ok ? ackn + 1 : TMO + 1;
        checks++; if (o_hung || o_stall != e_stall || o_req != e_stall - 1 || o_done_err !== !ok) begin
          errors++; $display("FAIL rnd_timing[%0d] got stall=%0d req=%0d err=%b exp stall=%0d req=%0d err=%b", i, o_stall, o_req, o_done_err, e_stall, e_stall - 1, !ok); end
        checks++; if (o_addr !== {addr[31:2], 2'b00} || o_we !== is_store(op) || !o_stable) begin
          errors++; $display("FAIL rnd_bus[%0d] got addr=%h we=%b stable=%b exp addr=%h we=%b", i, o_addr, o_we, o_stable, {addr[31:2], 2'b00}, is_store(op)); end
        if (is_store(op)) begin
          checks++; if (o_be !== exp_be(op, addr) || o_wdata !== exp_wdata(op, data) || o_done_rd !== 5'd0) begin
            errors++; $display("FAIL rnd_store[%0d] got be=%b wdata=%h rd=%0d exp be=%b wdata=%h rd=0", i, o_be, o_wdata, o_done_rd, exp_be(op, addr), exp_wdata(op, data)); end
        end else if (ok) begin
          checks++; if (o_done_val !== exp_load(op, addr, rdata) || o_done_rd !== rd) begin
            errors++; $display("FAIL rnd_load[%0d] got val=%h rd=%0d exp val=%h rd=%0d", i, o_done_val, o_done_rd, exp_load(op, addr, rdata), rd); end
        end else begin
          checks++; if (o_done_rd !== 5'd0) begin errors++; $display("FAIL rnd_errload[%0d] got rd=%0d exp=0", i, o_done_rd); end
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_passthrough();
    test_load_ext();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
